// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit alu and the wide sequencer built on it.
// Holds the alu function codes, request opcodes, status bit positions and FSM states.
package alu_pkg;

    localparam logic [4:0] F_ADD = 5'b00100;
    localparam logic [4:0] F_ADC = 5'b00101;
    localparam logic [4:0] F_SUB = 5'b00110;
    localparam logic [4:0] F_SBB = 5'b00111;
    localparam logic [4:0] F_AND = 5'b01000;
    localparam logic [4:0] F_OR  = 5'b01001;
    localparam logic [4:0] F_XOR = 5'b01010;
    localparam logic [4:0] F_NOT = 5'b01011;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5
    } op_e;

    localparam int ST_CF = 5;
    localparam int ST_ZF = 4;
    localparam int ST_NF = 3;
    localparam int ST_VF = 2;
    localparam int ST_PF = 1;
    localparam int ST_AF = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response bundle for the wide sequencer: valid/ready request in, valid/ready response out.
interface alu_wide_seq_if #(
    parameter int NWORDS = 4
);
    localparam int W = 16 * NWORDS;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic         req_cin;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [5:0]   rsp_status;
    logic         rsp_err;

    modport master (
        output req_valid, req_op, req_cin, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_status, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_cin, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_status, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational 16-bit alu; ADD and ADC both fold in cin so a carry-in can seed word 0.
// Zero latency, no flow control.
module alu
    import alu_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [4:0]  f_i,
    input  logic        cin_i,
    output logic [15:0] res_o,
    output logic        cf_o,
    output logic        vf_o,
    output logic        af_o
);
    logic [16:0] sum;
    logic [15:0] hx;

    always_comb begin
        sum   = '0;
        res_o = '0;
        cf_o  = 1'b0;
        vf_o  = 1'b0;
        hx    = '0;
        af_o  = 1'b0;
        case (f_i)
            F_ADD, F_ADC: begin
                sum   = {1'b0, a_i} + {1'b0, b_i} + {16'b0, cin_i};
                res_o = sum[15:0];
                cf_o  = sum[16];
                vf_o  = (a_i[15] == b_i[15]) && (res_o[15] != a_i[15]);
            end
            F_SUB, F_SBB: begin
                // Bit 16 of the 17-bit difference is the borrow out.
                sum   = {1'b0, a_i} - {1'b0, b_i} - {16'b0, cin_i};
                res_o = sum[15:0];
                cf_o  = sum[16];
                vf_o  = (a_i[15] != b_i[15]) && (res_o[15] != a_i[15]);
            end
            F_AND: res_o = a_i & b_i;
            F_OR:  res_o = a_i | b_i;
            F_XOR: res_o = a_i ^ b_i;
            F_NOT: res_o = ~a_i;
            default: res_o = '0;
        endcase
        hx   = a_i ^ b_i ^ res_o;
        af_o = hx[4];
    end
endmodule

// File: rtl/alu_wide_seq.sv
// Wide ALU sequencer: streams an NWORDS*16-bit op through one 16-bit alu, LS word first.
// Response NWORDS cycles after accept; holds response until rsp_ready, refuses requests meanwhile.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int NWORDS = 4
)(
    input  logic          clk,
    input  logic          rst,
    alu_wide_seq_if.slave bus
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  result_q;
    logic          af_q, cf_q, vf_q, err_q;
    op_e           op_q;
    logic          cin_q;
    logic [W-1:0]  a_q, b_q;

    logic          req_fire;
    logic          is_arith;
    logic [4:0]    alu_f;
    logic          alu_cin;
    logic [15:0]   alu_a, alu_b, alu_res;
    logic          alu_cf, alu_vf, alu_af;

    assign req_fire = bus.req_valid && bus.req_ready;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign alu_a    = a_q[int'(idx_q)*16 +: 16];
    assign alu_b    = b_q[int'(idx_q)*16 +: 16];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_fire) state_d = op_legal(bus.req_op) ? S_RUN : S_DONE;
            S_RUN:  if (idx_q == LAST) state_d = S_DONE;
            S_DONE: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE) && !rst;
        bus.rsp_valid = (state_q == S_DONE);
        alu_f   = F_ADD;
        alu_cin = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_f   = (idx_q == '0) ? F_ADD : F_ADC;
                alu_cin = (idx_q == '0) ? cin_q : carry_q;
            end
            OP_SUB: begin
                alu_f   = (idx_q == '0) ? F_SUB : F_SBB;
                alu_cin = (idx_q == '0) ? cin_q : carry_q;
            end
            OP_AND:  alu_f = F_AND;
            OP_OR:   alu_f = F_OR;
            OP_XOR:  alu_f = F_XOR;
            OP_NOT:  alu_f = F_NOT;
            default: alu_f = F_ADD;
        endcase
    end

    alu u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .f_i   (alu_f),
        .cin_i (alu_cin),
        .res_o (alu_res),
        .cf_o  (alu_cf),
        .vf_o  (alu_vf),
        .af_o  (alu_af)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            af_q     <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= OP_ADD;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (state_q == S_IDLE && req_fire) begin
            op_q     <= op_e'(bus.req_op);
            cin_q    <= bus.req_cin;
            a_q      <= bus.req_a;
            b_q      <= bus.req_b;
            err_q    <= !op_legal(bus.req_op);
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            af_q     <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
        end else if (state_q == S_RUN) begin
            result_q[int'(idx_q)*16 +: 16] <= alu_res;
            idx_q   <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
            carry_q <= alu_cf;
            // Flags stay cleared for logic ops so they never leak into status.
            if (is_arith) begin
                cf_q <= alu_cf;
                vf_q <= alu_vf;
                if (idx_q == '0) af_q <= alu_af;
            end
        end
    end

    always_comb begin
        bus.rsp_status = '0;
        if (state_q == S_DONE) begin
            bus.rsp_status[ST_CF] = cf_q;
            bus.rsp_status[ST_ZF] = (result_q == '0);
            bus.rsp_status[ST_NF] = result_q[W-1];
            bus.rsp_status[ST_VF] = vf_q;
            bus.rsp_status[ST_PF] = ~^result_q;
            bus.rsp_status[ST_AF] = af_q;
        end
    end

    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q && (state_q == S_DONE);
endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq (NWORDS=4) with hand-computed results and status.
module tb_alu_wide_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    alu_wide_seq_if #(.NWORDS(4)) bus ();

    alu_wide_seq #(.NWORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic cin,
                         input logic [63:0] a, input logic [63:0] b);
        chk("req_ready_before_issue", 64'(bus.req_ready), 64'd1);
        bus.req_op    = op;
        bus.req_cin   = cin;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] res,
                             input logic [5:0] st, input logic err);
        chk({tag, "_result"}, bus.rsp_result, res);
        chk({tag, "_status"}, 64'(bus.rsp_status), 64'(st));
        chk({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_handshake", 64'(bus.rsp_valid), 64'd0);
        chk("req_ready_after_handshake", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic cin,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] res, input logic [5:0] st);
        int n;
        issue(op, cin, a, b);
        wait_rsp(n);
        chk({tag, "_latency"}, 64'(n), 64'd4);
        check_rsp(tag, res, st, 1'b0);
        release_rsp();
    endtask

    initial begin
        int  n;
        logic [63:0] held_res;
        logic [5:0]  held_st;
        logic        seen_valid;

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_cin   = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        chk("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_req_ready_low", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        run_op("add_word_carry", 3'd0, 1'b0, 64'h0000_0000_0000_FFFF, 64'd1,
               64'h0000_0000_0001_0000, 6'b000001);
        run_op("add_wrap", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'h0, 6'b110011);
        run_op("sub_borrow_chain", 3'd1, 1'b0, 64'h0, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 6'b101011);
        run_op("add_signed_ovf", 3'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               64'h8000_0000_0000_0000, 6'b001101);
        run_op("xor_self", 3'd4, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
               64'h0, 6'b010010);
        run_op("not_zero", 3'd5, 1'b0, 64'h0, 64'h5555_5555_5555_5555,
               64'hFFFF_FFFF_FFFF_FFFF, 6'b001010);
        run_op("add_cin", 3'd0, 1'b1, 64'h0, 64'h0, 64'h1, 6'b000000);
        run_op("sub_bin", 3'd1, 1'b1, 64'h5, 64'h2, 64'h2, 6'b000000);
        run_op("or_mix", 3'd3, 1'b1, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_000F,
               64'hF000_0000_0000_000F, 6'b001010);

        // Response backpressure: outputs must hold while rsp_ready stays low.
        issue(3'd2, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
        wait_rsp(n);
        chk("bp_latency", 64'(n), 64'd4);
        check_rsp("bp_first", 64'h0F0F_0000_0F0F_0000, 6'b000010, 1'b0);
        held_res = bus.rsp_result;
        held_st  = bus.rsp_status;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", 64'(bus.rsp_valid), 64'd1);
            chk("bp_result_held", bus.rsp_result, 64'h0F0F_0000_0F0F_0000);
            chk("bp_status_held", 64'(bus.rsp_status), 64'(6'b000010));
            chk("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        check_rsp("bp_last", held_res, held_st, 1'b0);
        release_rsp();

        // Illegal opcode goes straight to a response.
        issue(3'd7, 1'b1, 64'h1234, 64'h5678);
        wait_rsp(n);
        chk("illegal_latency_le1", 64'(n <= 1), 64'd1);
        check_rsp("illegal", 64'h0, 6'b010010, 1'b1);
        release_rsp();

        // Reset during RUN abandons the op.
        issue(3'd0, 1'b0, 64'h1, 64'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_req_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_mid_result_clear", bus.rsp_result, 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("rst_mid_no_rsp", 64'(seen_valid), 64'd0);

        run_op("after_rst_add", 3'd0, 1'b0, 64'h0001_0000_0000_FFFF, 64'h0000_0000_0000_0001,
               64'h0001_0000_0001_0000, 6'b000011);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
